// File: rtl/uart_tx_core.sv
// uart_tx_core -- FIFO-buffered asynchronous serial transmitter.
//
// A FIFO_DEPTH-entry character FIFO feeds a frame engine that sends
// start bit, DATA_BITS data bits (LSB first), an optional parity bit and
// STOP_BITS stop bits, each bit held for CLK_DIV clocks. Frames queued in
// the FIFO go out back to back with no idle gap.
//
// Optional feature: define UART_TX_PARITY_EN to insert one parity bit
// (XOR of the data bits, inverted when parity_odd was 1 at pop time).
// Without it parity_odd is ignored and the PARITY state is unreachable.
//
// Parameters:
//   CLK_DIV    clocks per serial bit (2..2047)
//   DATA_BITS  data bits per frame (5..8)
//   STOP_BITS  stop bits per frame (1 or 2)
//   FIFO_DEPTH transmit FIFO entries (power of two, 2..16)
//
// Ports:
//   clock      system clock, single domain
//   reset      asynchronous, active-low reset
//   wr_data    character to enqueue
//   wr_valid   write request, taken when wr_ready is high
//   wr_ready   FIFO has room (registered occupancy only)
//   parity_odd parity sense, 1 = odd, 0 = even (latched per character)
//   tx         serial line, idle high, registered
//   busy       frame in flight or FIFO non-empty
//   fifo_count current FIFO occupancy

module uart_tx_core #(
    parameter int CLK_DIV    = 104,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [DATA_BITS-1:0]        wr_data,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic                        parity_odd,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    // ------------------------------------------------------------------
    // Transmit FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [DATA_BITS-1:0] head;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;

    // Ready looks only at the registered count, so a pop in the same
    // cycle never opens a slot early.
    assign wr_ready   = (fifo_count < CW'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign push       = wr_valid && wr_ready;
    assign head       = mem[rd_ptr];

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame engine state
    // ------------------------------------------------------------------
    logic [2:0]           state;
    logic [DW-1:0]        div;
    logic [BW-1:0]        bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 bit_end;
    logic                 last_data;
    logic                 last_stop;

    assign bit_end   = (div == DW'(CLK_DIV - 1));
    assign last_data = (bit_idx == BW'(DATA_BITS - 1));
    assign last_stop = (STOP_BITS == 1) || stop_idx;

    // A character leaves the FIFO either straight from IDLE or on the
    // final stop clock, which is what makes back-to-back frames gapless.
    assign pop = !fifo_empty &&
                 ((state == IDLE) || ((state == STOP) && bit_end && last_stop));

    assign busy = (state != IDLE) || !fifo_empty;

    // ------------------------------------------------------------------
    // Parity bit, computed once per character when it is popped
    // ------------------------------------------------------------------
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
    logic par_bit;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            par_bit <= 1'b0;
        end else if (pop) begin
            par_bit <= (^head) ^ parity_odd;
        end
    end
`else
    localparam bit PAR_EN = 1'b0;
    logic par_bit;
    logic unused_parity_odd;

    assign par_bit           = 1'b1;
    assign unused_parity_odd = parity_odd;
`endif

    // ------------------------------------------------------------------
    // Bit sequencer. tx is registered: every bit value is loaded on the
    // edge that enters its bit period.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            div      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            tx       <= 1'b1;
        end else begin
            // Divider runs only while a frame is in flight; every bit
            // boundary wraps it back to zero.
            if (state != IDLE) begin
                div <= bit_end ? '0 : div + DW'(1);
            end

            case (state)
                IDLE: begin
                    if (pop) begin
                        state <= START;
                        shreg <= head;
                        tx    <= 1'b0;
                        div   <= '0;
                    end
                end

                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= '0;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        if (!last_data) begin
                            bit_idx <= bit_idx + BW'(1);
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                        end else if (PAR_EN) begin
                            state <= PARITY;
                            tx    <= par_bit;
                        end else begin
                            state    <= STOP;
                            tx       <= 1'b1;
                            stop_idx <= 1'b0;
                        end
                    end
                end

                PARITY: begin
                    if (bit_end) begin
                        state    <= STOP;
                        tx       <= 1'b1;
                        stop_idx <= 1'b0;
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        if (!last_stop) begin
                            stop_idx <= 1'b1;
                        end else if (pop) begin
                            state <= START;
                            shreg <= head;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core.
// dut0: CLK_DIV=4, DATA_BITS=8, STOP_BITS=1, FIFO_DEPTH=4.
// dut1: CLK_DIV=4, DATA_BITS=7, STOP_BITS=2, FIFO_DEPTH=4.
// Expected characters are queued when written and popped by a serial
// monitor that compares every clock of every dut0 frame.

module tb_uart_tx_core;

    localparam int CD = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FRAME0 = (1 + 8 + P + 1) * CD;
    localparam int FRAME1 = (1 + 7 + P + 2) * CD;

    logic       clock = 1'b0;
    logic       reset = 1'b1;

    logic [7:0] wr_data0 = '0;
    logic       wr_valid0 = 1'b0;
    logic       parity_odd0 = 1'b0;
    logic       wr_ready0, tx0, busy0;
    logic [2:0] cnt0;

    logic [6:0] wr_data1 = '0;
    logic       wr_valid1 = 1'b0;
    logic       parity_odd1 = 1'b0;
    logic       wr_ready1, tx1, busy1;
    logic [2:0] cnt1;

    always #5 clock = ~clock;

    uart_tx_core #(.CLK_DIV(CD), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
        .clock(clock), .reset(reset), .wr_data(wr_data0), .wr_valid(wr_valid0),
        .wr_ready(wr_ready0), .parity_odd(parity_odd0), .tx(tx0), .busy(busy0),
        .fifo_count(cnt0)
    );

    uart_tx_core #(.CLK_DIV(CD), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(4)) dut1 (
        .clock(clock), .reset(reset), .wr_data(wr_data1), .wr_valid(wr_valid1),
        .wr_ready(wr_ready1), .parity_odd(parity_odd1), .tx(tx1), .busy(busy1),
        .fifo_count(cnt1)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    logic mon_en = 1'b1;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       par;
    } exp_t;

    exp_t sb0[$];
    int   starts0[$];

    // Serial monitor for dut0: a low line at a negedge while idle marks
    // clock 0 of a frame; every following clock is compared.
    initial begin : rx_mon
        exp_t e;
        int   errs;
        int   b;
        logic eb;
        forever begin
            @(negedge clock);
            if (mon_en && reset && tx0 == 1'b0) begin
                starts0.push_back(cyc);
                chk("sb_nonempty", 32'(sb0.size() != 0), 1);
                if (sb0.size() != 0) e = sb0.pop_front();
                else begin e.d = 8'h00; e.par = 1'b0; end
                errs = 0;
                for (int c = 0; c < FRAME0; c++) begin
                    if (c > 0) @(negedge clock);
                    b = c / CD;
                    if (b == 0)                eb = 1'b0;
                    else if (b <= 8)           eb = e.d[b-1];
                    else if (P == 1 && b == 9) eb = e.par;
                    else                       eb = 1'b1;
                    if (tx0 !== eb || busy0 !== 1'b1) errs++;
                end
                chk($sformatf("frame_%02h_bad_clocks", e.d), errs, 0);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] d;
        logic       podd;
        logic       par;
        int         lat;
        int         len;
        int         cnt;
    } vec_t;

    vec_t       vecs [6];
    logic [7:0] bdat [5];
    logic       bpar [5];
    logic       brdy [5];
    int         bcnt [5];

    initial begin : main
        int lat, len, t, errs, run, quiet;
        logic eb;
        logic seen_low;

        // parity bit = XOR of data, inverted for odd sense
        vecs[0] = '{8'h55, 1'b0, 1'b0, 1, FRAME0, 1};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 1, FRAME0, 1};
        vecs[2] = '{8'hFF, 1'b0, 1'b0, 1, FRAME0, 1};
        vecs[3] = '{8'h07, 1'b0, 1'b1, 1, FRAME0, 1};
        vecs[4] = '{8'h07, 1'b1, 1'b0, 1, FRAME0, 1};
        vecs[5] = '{8'h80, 1'b1, 1'b0, 1, FRAME0, 1};
        bdat = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
        bpar = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        brdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        bcnt = '{0, 1, 2, 3, 4};

        // ---- reset state
        #2 reset = 1'b0;
        #1;
        chk("rst_tx0", tx0, 1);
        chk("rst_busy0", busy0, 0);
        chk("rst_ready0", wr_ready0, 1);
        chk("rst_cnt0", cnt0, 0);
        chk("rst_tx1", tx1, 1);
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b1;

        // ---- single characters from idle
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            wr_data0    = vecs[i].d;
            parity_odd0 = vecs[i].podd;
            wr_valid0   = 1'b1;
            sb0.push_back('{vecs[i].d, vecs[i].par});
            @(posedge clock);
            #1 wr_valid0 = 1'b0;
            chk("cnt_after_write", cnt0, vecs[i].cnt);
            lat = 0;
            while (tx0 && lat < 20) begin @(posedge clock); #1; lat++; end
            chk("fall_latency", lat, vecs[i].lat);
            len = 0;
            while (busy0 && len < 500) begin @(posedge clock); #1; len++; end
            chk("busy_clocks", len, vecs[i].len);
        end

        // ---- FIFO fill while a frame is in flight, then gapless drain
        @(negedge clock);
        wr_data0 = 8'h3C; parity_odd0 = 1'b0; wr_valid0 = 1'b1;
        sb0.push_back('{8'h3C, 1'b0});
        @(posedge clock);
        #1 wr_valid0 = 1'b0;
        starts0.delete();
        t = 0;
        while (tx0 && t < 20) begin @(posedge clock); #1; t++; end
        chk("burst_lead_started", tx0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk($sformatf("burst_ready_%0d", i), wr_ready0, brdy[i]);
            chk($sformatf("burst_cnt_%0d", i), cnt0, bcnt[i]);
            wr_data0  = bdat[i];
            wr_valid0 = 1'b1;
            if (brdy[i]) sb0.push_back('{bdat[i], bpar[i]});
        end
        @(negedge clock);
        wr_valid0 = 1'b0;
        chk("full_cnt", cnt0, 4);
        chk("full_ready", wr_ready0, 0);
        t = 0;
        while (busy0 && t < 2000) begin @(posedge clock); #1; t++; end
        chk("burst_drained", busy0, 0);
        chk("burst_frames", starts0.size(), 5);
        for (int k = 1; k < starts0.size() && k < 5; k++)
            chk($sformatf("burst_gap_%0d", k), starts0[k] - starts0[k-1], FRAME0);
        chk("sb_empty_e5_dropped", sb0.size(), 0);

        // ---- dut1: 7 data bits, 2 stop bits, second frame right behind
        @(negedge clock);
        wr_data1 = 7'h7F; parity_odd1 = 1'b0; wr_valid1 = 1'b1;
        @(negedge clock);
        chk("d1_line_idle_before_start", tx1, 1);
        wr_data1 = 7'h00;
        @(negedge clock);
        wr_valid1 = 1'b0;
        errs = 0; run = 0; seen_low = 1'b0;
        for (int c = 0; c <= FRAME1; c++) begin
            if (c > 0) @(negedge clock);
            if (c < CD)                 eb = 1'b0;
            else if (c == FRAME1)       eb = 1'b0;
            else                        eb = 1'b1;
            if (tx1 !== eb) errs++;
            if (c >= CD && !seen_low) begin
                if (tx1 === 1'b1) run++;
                else seen_low = 1'b1;
            end
        end
        chk("d1_wave_bad_clocks", errs, 0);
        chk("d1_high_run", run, (7 + P + 2) * CD);
        t = 0;
        while (busy1 && t < 500) begin @(posedge clock); #1; t++; end
        chk("d1_drained", busy1, 0);

        // ---- reset mid-frame with two characters queued
        mon_en = 1'b0;
        @(negedge clock);
        wr_data0 = 8'h00; parity_odd0 = 1'b0; wr_valid0 = 1'b1;
        repeat (3) @(negedge clock);
        wr_valid0 = 1'b0;
        chk("rq_queued", cnt0, 2);
        repeat (9) @(posedge clock);
        #2;
        chk("rq_mid_frame_low", tx0, 0);
        reset = 1'b0;
        #1;
        chk("rq_tx_high", tx0, 1);
        chk("rq_cnt", cnt0, 0);
        chk("rq_busy", busy0, 0);
        chk("rq_ready", wr_ready0, 1);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        quiet = 0;
        repeat (100) begin
            @(negedge clock);
            if (tx0 !== 1'b1 || busy0 !== 1'b0) quiet++;
        end
        chk("rq_line_quiet_after_release", quiet, 0);
        chk("rq_cnt_after_release", cnt0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_tx_core.md
UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
REQ-001 SHALL have parameter CLK_DIV, default 104, clocks per serial bit (legal range 2..2047).
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame (legal range 5..8).
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits per frame (legal values 1 or 2).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, transmit FIFO entries (power of two, 2..16).
REQ-005 SHALL have port clock, input, 1, system clock; all logic in this single domain.
REQ-006 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-007 SHALL have port wr_data, input, DATA_BITS, character to enqueue.
REQ-008 SHALL have port wr_valid, input, 1, write request.
REQ-009 SHALL have port wr_ready, output, 1, FIFO can accept a word.
REQ-010 SHALL have port parity_odd, input, 1, parity sense (1 = odd, 0 = even).
REQ-011 SHALL have port tx, output, 1, serial line, idle high, registered.
REQ-012 SHALL have port busy, output, 1, high when a frame is in flight or the FIFO is non-empty.
REQ-013 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.

Function
REQ-014 SHALL accept a write on a rising clock edge where wr_valid=1 and wr_ready=1; fifo_count increments on that edge.
REQ-015 SHALL drive wr_ready = (fifo_count < FIFO_DEPTH), from registered state only and independent of a same-cycle pop.
REQ-016 SHALL ignore wr_valid when wr_ready=0; no overwrite and no count change.
REQ-017 SHALL wrap FIFO read and write pointers modulo FIFO_DEPTH; a simultaneous push and pop leaves fifo_count unchanged.
REQ-018 SHALL use the FSM states IDLE, START, DATA, PARITY and STOP.
REQ-019 In IDLE with fifo_count>0, on the next edge SHALL pop the head word into the shift register, latch parity_odd, enter START, drive tx=0 and clear the divider.
REQ-020 SHALL hold each bit for exactly CLK_DIV clocks, using a divider that counts 0..CLK_DIV-1 and runs only outside IDLE.
REQ-021 In DATA SHALL shift DATA_BITS bits out LSB first.
REQ-022 SHALL enter PARITY after DATA only when parity is compiled in (REQ-030); otherwise DATA goes directly to STOP.
REQ-023 SHALL hold tx=1 in STOP for STOP_BITS*CLK_DIV clocks.
REQ-024 At the last STOP clock, with fifo_count>0, SHALL pop and enter START on the same edge (no idle gap); otherwise SHALL enter IDLE.
REQ-025 Total frame length SHALL be (1+DATA_BITS+P+STOP_BITS)*CLK_DIV clocks, where P = 1 if parity is compiled in, else 0.
REQ-026 A write into an empty FIFO while IDLE SHALL produce the tx falling edge exactly one clock after the write edge.
REQ-027 SHALL drive busy = (state != IDLE) || (fifo_count != 0).

Reset
REQ-028 While reset=0, asynchronously and regardless of state, SHALL force: tx=1, state=IDLE, divider=0, FIFO pointers=0, fifo_count=0, wr_ready=1, busy=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame, flush the FIFO and emit no further bits; the first edge after release begins in IDLE.

Configuration
REQ-030 With macro UART_TX_PARITY_EN defined, SHALL insert one parity bit after the data (XOR of data bits, inverted when the latched parity_odd=1), held for CLK_DIV clocks.
REQ-031 Without UART_TX_PARITY_EN, the PARITY state SHALL be unreachable, parity_odd SHALL be ignored and P = 0.

Verification
REQ-032 CLK_DIV=4, DATA_BITS=8, STOP_BITS=1, no parity; write 0x55 -> tx 0,1,0,1,0,1,0,1,0,1, 4 clocks each; falling edge 1 clock after the write; busy high for 40 clocks.
REQ-033 FIFO_DEPTH=4, CLK_DIV=4; write 0xA1, 0xB2, 0xC3, 0xD4, 0xE5 on consecutive cycles -> wr_ready drops only after the full condition, 0xE5 is dropped, and 4 back-to-back frames go out with no idle gap between them.
REQ-034 UART_TX_PARITY_EN defined, CLK_DIV=4; send 0x07 with parity_odd=0 -> parity bit 1; with parity_odd=1 -> parity bit 0; each frame is 44 clocks.
REQ-035 STOP_BITS=2, DATA_BITS=7; send 0x7F -> 7 data ones, then tx high for 8 clocks before the next start bit.
REQ-036 Assert reset 10 clocks into a frame with 2 words queued -> tx=1 immediately, fifo_count=0, busy=0, and tx stays high after release.
